// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: frame tick and keypad codes in, game state out.
// The controller is the slave; the driver of ticks and keys is the master.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic [3:0] keys_1;
  logic [3:0] keys_2;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] state;
  logic [7:0] led;

  modport master (
    output frame_tick, keys_1, keys_2,
    input  paddle1_y, paddle2_y,
    input  ball_x, ball_y,
    input  score1, score2, state, led
  );

  modport slave (
    input  frame_tick, keys_1, keys_2,
    output paddle1_y, paddle2_y,
    output ball_x, ball_y,
    output score1, score2, state, led
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: paddles, ball, scores and match FSM,
// all advanced once per frame tick.
module pong_game_ctrl #(
  parameter int         H_ACTIVE     = 640,
  parameter int         V_ACTIVE     = 480,
  parameter int         PADDLE_H     = 64,
  parameter int         PADDLE_W     = 8,
  parameter int         PADDLE_X1    = 16,
  parameter int         PADDLE_X2    = 616,
  parameter int         BALL_SIZE    = 8,
  parameter int         PADDLE_SPEED = 4,
  parameter int         BALL_SPEED   = 2,
  parameter int         WIN_SCORE    = 9,
  parameter int         SERVE_DELAY  = 60,
  parameter logic [3:0] KEY_UP       = 4'h2,
  parameter logic [3:0] KEY_DN       = 4'h8,
  parameter logic [3:0] KEY_SERVE    = 4'h5
) (
  input logic             CLOCK_50,
  input logic             rst_n,
  pong_game_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_OVER  = 2'd3;

  localparam int CW = $clog2(SERVE_DELAY);
  localparam logic [CW-1:0] CLAST = CW'(SERVE_DELAY - 1);

  localparam logic [10:0] PMAX  = 11'(V_ACTIVE - PADDLE_H);
  localparam logic [10:0] BYMAX = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic [10:0] BXMAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic [10:0] LHIT  = 11'(PADDLE_X1 + PADDLE_W);
  localparam logic [10:0] RHIT  = 11'(PADDLE_X2 - BALL_SIZE);
  localparam logic [10:0] XR    = 11'(PADDLE_X2);
  localparam logic [10:0] PH    = 11'(PADDLE_H);
  localparam logic [10:0] BS    = 11'(BALL_SIZE);
  localparam logic [10:0] BSPD  = 11'(BALL_SPEED);
  localparam logic [10:0] PSPD  = 11'(PADDLE_SPEED);

  localparam logic [9:0] CX  = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] CY  = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] PY0 = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  logic [9:0]    p1_q, p1_d, p2_q, p2_d;
  logic [9:0]    bx_q, bx_d, by_q, by_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic [1:0]    st_q, st_d;
  logic          dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [10:0] bx_e, by_e, p1_e, p2_e;
  logic        ov1, ov2, serve, pt1, pt2;

  assign bx_e  = {1'b0, bx_q};
  assign by_e  = {1'b0, by_q};
  assign p1_e  = {1'b0, p1_q};
  assign p2_e  = {1'b0, p2_q};
  assign ov1   = (by_e + BS > p1_e) && (by_e < p1_e + PH);
  assign ov2   = (by_e + BS > p2_e) && (by_e < p2_e + PH);
  assign serve = (bus.keys_1 == KEY_SERVE) ||
                 (bus.keys_2 == KEY_SERVE);

  function automatic logic [9:0] pad_next(
    input logic [9:0] y,
    input logic [3:0] k
  );
    pad_next = y;
    if (k == KEY_UP)
      pad_next = ({1'b0, y} < PSPD) ? '0 : y - PSPD[9:0];
    else if (k == KEY_DN)
      pad_next = ({1'b0, y} + PSPD > PMAX) ?
                 PMAX[9:0] : y + PSPD[9:0];
  endfunction

  always_comb begin
    p1_d  = p1_q;
    p2_d  = p2_q;
    bx_d  = bx_q;
    by_d  = by_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    st_d  = st_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    cnt_d = cnt_q;
    pt1   = 1'b0;
    pt2   = 1'b0;
    if (bus.frame_tick) begin
      unique case (1'b1)
        st_q == S_IDLE: begin
          if (serve) begin
            st_d  = S_SERVE;
            cnt_d = '0;
            bx_d  = CX;
            by_d  = CY;
          end
        end
        st_q == S_SERVE: begin
          p1_d = pad_next(p1_q, bus.keys_1);
          p2_d = pad_next(p2_q, bus.keys_2);
          bx_d = CX;
          by_d = CY;
          if (cnt_q == CLAST) begin
            st_d  = S_PLAY;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        st_q == S_PLAY: begin
          p1_d = pad_next(p1_q, bus.keys_1);
          p2_d = pad_next(p2_q, bus.keys_2);
          if (dy_q) begin
            if (by_e + BSPD >= BYMAX) begin
              by_d = BYMAX[9:0];
              dy_d = 1'b0;
            end else begin
              by_d = by_q + BSPD[9:0];
            end
          end else if (by_e <= BSPD) begin
            by_d = '0;
            dy_d = 1'b1;
          end else begin
            by_d = by_q - BSPD[9:0];
          end
          // Hit and miss tests only apply on the side the ball heads to
          if (dx_q) begin
            if (bx_e + BS <= XR && bx_e + BS + BSPD >= XR && ov2) begin
              bx_d = RHIT[9:0];
              dx_d = 1'b0;
            end else if (bx_e + BSPD >= BXMAX) begin
              pt1 = 1'b1;
            end else begin
              bx_d = bx_q + BSPD[9:0];
            end
          end else begin
            if (bx_e >= LHIT && bx_e <= LHIT + BSPD && ov1) begin
              bx_d = LHIT[9:0];
              dx_d = 1'b1;
            end else if (bx_e <= BSPD) begin
              pt2 = 1'b1;
            end else begin
              bx_d = bx_q - BSPD[9:0];
            end
          end
          if (pt1 || pt2) begin
            bx_d  = CX;
            by_d  = CY;
            cnt_d = '0;
            dx_d  = pt1;
            st_d  = S_SERVE;
            if (pt1 && s1_q != WIN) begin
              s1_d = s1_q + 4'd1;
              if (s1_q + 4'd1 == WIN) st_d = S_OVER;
            end
            if (pt2 && s2_q != WIN) begin
              s2_d = s2_q + 4'd1;
              if (s2_q + 4'd1 == WIN) st_d = S_OVER;
            end
          end
        end
        default: begin
          if (serve) begin
            st_d  = S_IDLE;
            s1_d  = '0;
            s2_d  = '0;
            p1_d  = PY0;
            p2_d  = PY0;
            bx_d  = CX;
            by_d  = CY;
            dx_d  = 1'b1;
            dy_d  = 1'b1;
            cnt_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      p1_q  <= PY0;
      p2_q  <= PY0;
      bx_q  <= CX;
      by_q  <= CY;
      s1_q  <= '0;
      s2_q  <= '0;
      st_q  <= S_IDLE;
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
      cnt_q <= '0;
    end else begin
      p1_q  <= p1_d;
      p2_q  <= p2_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      st_q  <= st_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.paddle1_y = p1_q;
  assign bus.paddle2_y = p2_q;
  assign bus.ball_x    = bx_q;
  assign bus.ball_y    = by_q;
  assign bus.score1    = s1_q;
  assign bus.score2    = s2_q;
  assign bus.state     = st_q;
  assign bus.led       = {s1_q, s2_q};

endmodule
